// File: rtl/pll_seq_pkg.sv
// Shared types and widths for the PLL lock sequencer.
// The relock counter helper is used only when PLL_SEQ_RELOCK_CNT_EN is defined.
package pll_seq_pkg;

    localparam int unsigned SEQ_STATE_W  = 3;
    localparam int unsigned RELOCK_CNT_W = 8;

    typedef enum logic [SEQ_STATE_W-1:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_RUN       = 3'd4,
        ST_FAULT     = 3'd5
    } seq_state_t;

    function automatic logic [RELOCK_CNT_W-1:0] sat_inc(input logic [RELOCK_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/pll_seq_sync2.sv
// Two-flop synchronizer for a single-bit level from another clock domain.
// Both stages reset to 0 so the lock indication reads "unlocked" after reset.
module pll_seq_sync2 (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL bring-up sequencer: reset pulse, lock wait with retries, lock debounce, staggered domain release.
// Optional PLL_SEQ_RELOCK_CNT_EN adds the saturating relock_count output.
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int unsigned NUM_DOMAINS         = 5,
    parameter int unsigned RST_CYCLES          = 16,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
    parameter int unsigned STAGGER_CYCLES      = 8,
    parameter int unsigned MAX_RETRIES         = 7
) (
    input  logic                   refclk,
    input  logic                   rst,
    input  logic                   pll_locked_async,
    input  logic                   req_relock,
    output logic                   pll_rst,
    output logic [NUM_DOMAINS-1:0] domain_rst,
    output logic                   all_ready,
    output logic                   fault,
    output logic [SEQ_STATE_W-1:0] seq_state
`ifdef PLL_SEQ_RELOCK_CNT_EN
    ,
    output logic [RELOCK_CNT_W-1:0] relock_count
`endif
);

    localparam int unsigned RST_W   = $clog2(RST_CYCLES + 1);
    localparam int unsigned WAIT_W  = $clog2(LOCK_TIMEOUT_CYCLES + 1);
    localparam int unsigned STAB_W  = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam int unsigned STAG_W  = $clog2(STAGGER_CYCLES + 1);
    localparam int unsigned RETRY_W = 8;

    localparam logic [NUM_DOMAINS-1:0] DOM_ALL   = '1;
    localparam logic [NUM_DOMAINS-1:0] DOM_FIRST = DOM_ALL << 1;

    seq_state_t             state_q;
    logic                   pll_rst_q;
    logic [NUM_DOMAINS-1:0] domain_rst_q;
    logic                   all_ready_q;
    logic                   fault_q;

    logic [RST_W-1:0]       rst_tmr_q;
    logic [WAIT_W-1:0]      wait_tmr_q;
    logic [STAB_W-1:0]      stab_cnt_q;
    logic [STAG_W-1:0]      stag_tmr_q;
    logic [RETRY_W-1:0]     retry_q;

    logic                   lock_s;
    logic [RETRY_W-1:0]     retry_d;
    logic [NUM_DOMAINS-1:0] domain_shift_d;
    logic                   relock_evt_d;

    pll_seq_sync2 u_lock_sync (
        .clk_i (refclk),
        .rst_i (rst),
        .d_i   (pll_locked_async),
        .q_o   (lock_s)
    );

    always_comb begin
        retry_d        = retry_q + 1'b1;
        domain_shift_d = domain_rst_q << 1;
        relock_evt_d   = 1'b0;
        if (state_q == ST_RUN) begin
            relock_evt_d = !lock_s || req_relock;
        end else if (state_q == ST_RELEASE) begin
            relock_evt_d = !lock_s;
        end
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q      <= ST_PLL_RST;
            pll_rst_q    <= 1'b1;
            domain_rst_q <= DOM_ALL;
            all_ready_q  <= 1'b0;
            fault_q      <= 1'b0;
            rst_tmr_q    <= '0;
            wait_tmr_q   <= '0;
            stab_cnt_q   <= '0;
            stag_tmr_q   <= '0;
            retry_q      <= '0;
        end else if (relock_evt_d) begin
            // Lock loss or relock request once domains are being released: start over cleanly
            state_q      <= ST_PLL_RST;
            pll_rst_q    <= 1'b1;
            domain_rst_q <= DOM_ALL;
            all_ready_q  <= 1'b0;
            rst_tmr_q    <= '0;
            retry_q      <= '0;
        end else begin
            unique case (state_q)
                ST_PLL_RST: begin
                    if (rst_tmr_q == RST_W'(RST_CYCLES - 1)) begin
                        state_q    <= ST_WAIT_LOCK;
                        pll_rst_q  <= 1'b0;
                        wait_tmr_q <= '0;
                    end else begin
                        rst_tmr_q <= rst_tmr_q + 1'b1;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (lock_s) begin
                        // The sample that ends the wait is the first of the stable run
                        state_q    <= ST_STABLE;
                        stab_cnt_q <= STAB_W'(1);
                    end else if (wait_tmr_q == WAIT_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
                        retry_q    <= retry_d;
                        wait_tmr_q <= '0;
                        pll_rst_q  <= 1'b1;
                        if (retry_d == RETRY_W'(MAX_RETRIES)) begin
                            state_q <= ST_FAULT;
                            fault_q <= 1'b1;
                        end else begin
                            state_q   <= ST_PLL_RST;
                            rst_tmr_q <= '0;
                        end
                    end else begin
                        wait_tmr_q <= wait_tmr_q + 1'b1;
                    end
                end
                ST_STABLE: begin
                    if (!lock_s) begin
                        state_q    <= ST_WAIT_LOCK;
                        wait_tmr_q <= '0;
                    end else if (stab_cnt_q >= STAB_W'(LOCK_STABLE_CYCLES - 1)) begin
                        domain_rst_q <= DOM_FIRST;
                        stag_tmr_q   <= '0;
                        if (DOM_FIRST == '0) begin
                            state_q     <= ST_RUN;
                            all_ready_q <= 1'b1;
                        end else begin
                            state_q <= ST_RELEASE;
                        end
                    end else begin
                        stab_cnt_q <= stab_cnt_q + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    // Domains release low bit first by shifting zeros in from the bottom
                    if (stag_tmr_q == STAG_W'(STAGGER_CYCLES - 1)) begin
                        stag_tmr_q   <= '0;
                        domain_rst_q <= domain_shift_d;
                        if (domain_shift_d == '0) begin
                            state_q     <= ST_RUN;
                            all_ready_q <= 1'b1;
                        end
                    end else begin
                        stag_tmr_q <= stag_tmr_q + 1'b1;
                    end
                end
                ST_RUN: begin
                end
                ST_FAULT: begin
                    pll_rst_q    <= 1'b1;
                    domain_rst_q <= DOM_ALL;
                    all_ready_q  <= 1'b0;
                    fault_q      <= 1'b1;
                end
                default: begin
                    state_q      <= ST_PLL_RST;
                    pll_rst_q    <= 1'b1;
                    domain_rst_q <= DOM_ALL;
                    all_ready_q  <= 1'b0;
                    rst_tmr_q    <= '0;
                end
            endcase
        end
    end

`ifdef PLL_SEQ_RELOCK_CNT_EN
    logic [RELOCK_CNT_W-1:0] relock_cnt_q;

    always_ff @(posedge refclk) begin
        if (rst) begin
            relock_cnt_q <= '0;
        end else if (relock_evt_d) begin
            relock_cnt_q <= sat_inc(relock_cnt_q);
        end
    end

    assign relock_count = relock_cnt_q;
`endif

    assign pll_rst    = pll_rst_q;
    assign domain_rst = domain_rst_q;
    assign all_ready  = all_ready_q;
    assign fault      = fault_q;
    assign seq_state  = state_q;

endmodule
